// File: rtl/page_stack_register.sv
// Memory page register with +/-1 stepping, absolute load and a small LIFO
// for saving/restoring the page across calls.
module page_stack_register #(
    parameter int unsigned PAGE_W      = 3,
    parameter int unsigned NUM_PAGES   = 8,
    parameter int unsigned SATURATE    = 0,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               increment,
    input  logic                               decrement,
    input  logic                               load,
    input  logic [PAGE_W-1:0]                  load_val,
    input  logic                               push,
    input  logic                               pop,
    output logic [PAGE_W-1:0]                  mem_page,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_count,
    output logic                               stack_full,
    output logic                               stack_empty,
    output logic                               boundary,
    output logic                               err
);

    localparam int unsigned CW    = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IW    = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int unsigned SLOTS = 1 << IW;

    localparam logic [PAGE_W-1:0] LAST_PAGE = PAGE_W'(NUM_PAGES - 1);
    localparam logic [CW-1:0]     DEPTH     = CW'(STACK_DEPTH);

    // Rounded up to a power of two so the count can index it without a range check.
    logic [PAGE_W-1:0] stack [SLOTS];

    logic [PAGE_W-1:0] page_nxt;
    logic [CW-1:0]     count_nxt;
    logic              boundary_nxt;
    logic              err_nxt;
    logic              wr_en;
    logic [IW-1:0]     wr_idx;
    logic [IW-1:0]     rd_idx;
    logic              load_bad;
    logic              step_up;
    logic              step_dn;

    assign stack_full  = (stack_count == DEPTH);
    assign stack_empty = (stack_count == '0);

    assign wr_idx   = IW'(stack_count);
    assign rd_idx   = IW'(stack_count - CW'(1));
    assign load_bad = (32'(load_val) >= NUM_PAGES);
    assign step_up  = increment && !decrement;
    assign step_dn  = decrement && !increment;

    always_comb begin
        page_nxt     = mem_page;
        count_nxt    = stack_count;
        boundary_nxt = 1'b0;
        err_nxt      = 1'b0;
        wr_en        = 1'b0;

        if (push && pop) begin
            err_nxt = 1'b1;
        end else if (pop && !stack_empty) begin
            page_nxt  = stack[rd_idx];
            count_nxt = stack_count - CW'(1);
        end else begin
            // A failed pop falls through so load/inc/dec still take effect.
            if (pop) begin
                err_nxt = 1'b1;
            end
            if (push) begin
                if (stack_full) begin
                    err_nxt = 1'b1;
                end else begin
                    wr_en     = 1'b1;
                    count_nxt = stack_count + CW'(1);
                end
            end
            if (load) begin
                if (load_bad) begin
                    err_nxt = 1'b1;
                end else begin
                    page_nxt = load_val;
                end
            end else if (step_up) begin
                if (mem_page == LAST_PAGE) begin
                    boundary_nxt = 1'b1;
                    if (SATURATE == 0) begin
                        page_nxt = '0;
                    end
                end else begin
                    page_nxt = mem_page + PAGE_W'(1);
                end
            end else if (step_dn) begin
                if (mem_page == '0) begin
                    boundary_nxt = 1'b1;
                    if (SATURATE == 0) begin
                        page_nxt = LAST_PAGE;
                    end
                end else begin
                    page_nxt = mem_page - PAGE_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_page    <= '0;
            stack_count <= '0;
            boundary    <= 1'b0;
            err         <= 1'b0;
        end else begin
            mem_page    <= page_nxt;
            stack_count <= count_nxt;
            boundary    <= boundary_nxt;
            err         <= err_nxt;
        end
    end

    // Entries are left stale on reset; stack_count alone marks what is valid.
    always_ff @(posedge clk) begin
        if (reset_n && wr_en) begin
            stack[wr_idx] <= mem_page;
        end
    end

endmodule

// File: tb/tb_page_stack_register.sv
// Directed bench for page_stack_register: default (wrap) and clamp instances,
// scoreboard queue filled by the driver and drained by a monitor.
module tb_page_stack_register;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: defaults (8 pages, wrap). Instance 1: 6 pages, clamp.
    logic       rn   [2];
    logic       inc  [2];
    logic       dec  [2];
    logic       ld   [2];
    logic [2:0] lv   [2];
    logic       pu   [2];
    logic       po   [2];
    logic [2:0] page [2];
    logic [2:0] cnt  [2];
    logic       full [2];
    logic       empt [2];
    logic       bnd  [2];
    logic       er   [2];

    page_stack_register u_wrap (
        .clk(clk), .reset_n(rn[0]), .increment(inc[0]), .decrement(dec[0]),
        .load(ld[0]), .load_val(lv[0]), .push(pu[0]), .pop(po[0]),
        .mem_page(page[0]), .stack_count(cnt[0]), .stack_full(full[0]),
        .stack_empty(empt[0]), .boundary(bnd[0]), .err(er[0])
    );

    page_stack_register #(.PAGE_W(3), .NUM_PAGES(6), .SATURATE(1), .STACK_DEPTH(4)) u_clamp (
        .clk(clk), .reset_n(rn[1]), .increment(inc[1]), .decrement(dec[1]),
        .load(ld[1]), .load_val(lv[1]), .push(pu[1]), .pop(po[1]),
        .mem_page(page[1]), .stack_count(cnt[1]), .stack_full(full[1]),
        .stack_empty(empt[1]), .boundary(bnd[1]), .err(er[1])
    );

    typedef struct {
        int         dut;
        logic [2:0] page;
        logic [2:0] cnt;
        logic       bnd;
        logic       err;
        string      name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 0;

    task automatic chk(input string nm, input string fld, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s.%s actual=%0d required=%0d", nm, fld, act, req);
        end
    endtask

    // Monitor: after each edge, compare the DUT named by the oldest expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk(e.name, "mem_page",    int'(page[e.dut]), int'(e.page));
                chk(e.name, "stack_count", int'(cnt[e.dut]),  int'(e.cnt));
                chk(e.name, "boundary",    int'(bnd[e.dut]),  int'(e.bnd));
                chk(e.name, "err",         int'(er[e.dut]),   int'(e.err));
                chk(e.name, "stack_full",  int'(full[e.dut]), (e.cnt == 3'd4) ? 1 : 0);
                chk(e.name, "stack_empty", int'(empt[e.dut]), (e.cnt == 3'd0) ? 1 : 0);
            end
        end
    end

    task automatic vec(input int d, input logic r, input logic i, input logic de,
                       input logic l, input logic [2:0] v, input logic ps, input logic pp,
                       input logic [2:0] ep, input logic [2:0] ec, input logic eb,
                       input logic ee, input string nm);
        exp_t e;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            inc[k] = 1'b0; dec[k] = 1'b0; ld[k] = 1'b0; lv[k] = '0; pu[k] = 1'b0; po[k] = 1'b0;
        end
        rn[d] = r; inc[d] = i; dec[d] = de; ld[d] = l; lv[d] = v; pu[d] = ps; po[d] = pp;
        e.dut = d; e.page = ep; e.cnt = ec; e.bnd = eb; e.err = ee; e.name = nm;
        q.push_back(e);
    endtask

    initial begin
        #20000;
        $display("FAIL timeout checks=%0d queued=%0d", checks, q.size());
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            rn[k] = 1'b0; inc[k] = 1'b0; dec[k] = 1'b0; ld[k] = 1'b0;
            lv[k] = '0; pu[k] = 1'b0; po[k] = 1'b0;
        end

        // Clamp instance (6 pages, saturate)
        //   d  rn  inc dec ld val  psh pop  page cnt bnd err
        vec(1, 0, 1, 0, 1, 3'd2, 1, 0, 3'd0, 3'd0, 0, 0, "c_reset");
        vec(1, 1, 0, 1, 0, 3'd0, 0, 0, 3'd0, 3'd0, 1, 0, "c_dec_at0_hold");
        vec(1, 1, 0, 0, 1, 3'd5, 0, 0, 3'd5, 3'd0, 0, 0, "c_load5");
        vec(1, 1, 1, 0, 0, 3'd0, 0, 0, 3'd5, 3'd0, 1, 0, "c_inc_at5_hold");
        vec(1, 1, 0, 0, 1, 3'd6, 0, 0, 3'd5, 3'd0, 0, 1, "c_load6_bad");
        vec(1, 1, 1, 0, 1, 3'd7, 0, 0, 3'd5, 3'd0, 0, 1, "c_load7_inc_suppr");
        vec(1, 1, 0, 1, 0, 3'd0, 0, 0, 3'd4, 3'd0, 0, 0, "c_dec_step");
        vec(1, 1, 0, 0, 1, 3'd6, 1, 0, 3'd4, 3'd1, 0, 1, "c_push_badload");
        vec(1, 1, 1, 0, 0, 3'd0, 0, 0, 3'd5, 3'd1, 0, 0, "c_inc_step");
        vec(1, 1, 0, 0, 0, 3'd0, 0, 1, 3'd4, 3'd0, 0, 0, "c_pop");

        // Wrap instance (defaults)
        vec(0, 0, 1, 0, 0, 3'd0, 1, 0, 3'd0, 3'd0, 0, 0, "reset");
        for (int n = 1; n <= 7; n++)
            vec(0, 1, 1, 0, 0, 3'd0, 0, 0, 3'(n), 3'd0, 0, 0, "wrap_inc");
        vec(0, 1, 1, 0, 0, 3'd0, 0, 0, 3'd0, 3'd0, 1, 0, "wrap_inc8");
        vec(0, 1, 0, 1, 0, 3'd0, 0, 0, 3'd7, 3'd0, 1, 0, "wrap_dec");
        vec(0, 1, 0, 1, 0, 3'd0, 0, 0, 3'd6, 3'd0, 0, 0, "dec_step");

        // Stack save/restore
        vec(0, 1, 0, 0, 1, 3'd3, 0, 0, 3'd3, 3'd0, 0, 0, "stk_load3");
        vec(0, 1, 0, 0, 1, 3'd6, 1, 0, 3'd6, 3'd1, 0, 0, "stk_push_load6");
        vec(0, 1, 1, 0, 0, 3'd0, 1, 0, 3'd7, 3'd2, 0, 0, "stk_push_inc");
        vec(0, 1, 0, 0, 0, 3'd0, 0, 1, 3'd6, 3'd1, 0, 0, "stk_pop1");
        vec(0, 1, 1, 0, 1, 3'd1, 0, 1, 3'd3, 3'd0, 0, 0, "stk_pop2_ign_ld");

        // Fill to depth, overflow, then drain in LIFO order
        vec(0, 1, 1, 0, 0, 3'd0, 1, 0, 3'd4, 3'd1, 0, 0, "lim_push1");
        vec(0, 1, 1, 0, 0, 3'd0, 1, 0, 3'd5, 3'd2, 0, 0, "lim_push2");
        vec(0, 1, 1, 0, 0, 3'd0, 1, 0, 3'd6, 3'd3, 0, 0, "lim_push3");
        vec(0, 1, 1, 0, 0, 3'd0, 1, 0, 3'd7, 3'd4, 0, 0, "lim_push4");
        vec(0, 1, 1, 0, 0, 3'd0, 1, 0, 3'd0, 3'd4, 1, 1, "lim_push5_full");
        vec(0, 1, 0, 0, 0, 3'd0, 0, 1, 3'd6, 3'd3, 0, 0, "lim_pop1");
        vec(0, 1, 0, 0, 0, 3'd0, 0, 1, 3'd5, 3'd2, 0, 0, "lim_pop2");
        vec(0, 1, 0, 0, 0, 3'd0, 0, 1, 3'd4, 3'd1, 0, 0, "lim_pop3");
        vec(0, 1, 0, 0, 0, 3'd0, 0, 1, 3'd3, 3'd0, 0, 0, "lim_pop4");
        vec(0, 1, 0, 0, 0, 3'd0, 0, 1, 3'd3, 3'd0, 0, 1, "lim_pop5_empty");

        // Collisions
        vec(0, 1, 0, 0, 1, 3'd4, 0, 0, 3'd4, 3'd0, 0, 0, "col_load4");
        vec(0, 1, 0, 0, 0, 3'd0, 1, 0, 3'd4, 3'd1, 0, 0, "col_push1");
        vec(0, 1, 0, 0, 0, 3'd0, 1, 0, 3'd4, 3'd2, 0, 0, "col_push2");
        vec(0, 1, 0, 0, 1, 3'd1, 1, 1, 3'd4, 3'd2, 0, 1, "col_push_pop");
        vec(0, 1, 1, 1, 0, 3'd0, 0, 0, 3'd4, 3'd2, 0, 0, "col_inc_dec");

        // Reset mid-operation
        vec(0, 1, 0, 0, 1, 3'd5, 1, 0, 3'd5, 3'd3, 0, 0, "rst_setup");
        vec(0, 0, 1, 0, 0, 3'd0, 0, 0, 3'd0, 3'd0, 0, 0, "rst_mid");
        vec(0, 1, 0, 0, 0, 3'd0, 0, 1, 3'd0, 3'd0, 0, 1, "rst_pop_empty");
        vec(0, 1, 1, 0, 0, 3'd0, 0, 1, 3'd1, 3'd0, 0, 1, "pop_empty_inc");

        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            inc[k] = 1'b0; dec[k] = 1'b0; ld[k] = 1'b0; pu[k] = 1'b0; po[k] = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        chk("drain", "queue_left", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/page_stack_register.md
PAGE_STACK_REGISTER -- requirements
Module: page_stack_register

Interface
REQ-001 SHALL have parameter PAGE_W, default 3, width of page number.
REQ-002 SHALL have parameter NUM_PAGES, default 8, legal pages 0..NUM_PAGES-1; constraint 2 <= NUM_PAGES <= 2**PAGE_W.
REQ-003 SHALL have parameter SATURATE, default 0, boundary mode: 0 = wrap, 1 = clamp.
REQ-004 SHALL have parameter STACK_DEPTH, default 4, save/restore stack entries; constraint >= 1.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port increment  input  1  request mem_page + 1.
REQ-008 SHALL have port decrement  input  1  request mem_page - 1.
REQ-009 SHALL have port load  input  1  request mem_page <= load_val.
REQ-010 SHALL have port load_val  input  PAGE_W  absolute page for load.
REQ-011 SHALL have port push  input  1  save current mem_page on stack.
REQ-012 SHALL have port pop  input  1  restore mem_page from top of stack.
REQ-013 SHALL have port mem_page  output  PAGE_W  current page, registered.
REQ-014 SHALL have port stack_count  output  $clog2(STACK_DEPTH+1)  occupied entries, registered.
REQ-015 SHALL have port stack_full / stack_empty  output  1 each  combinational decode of stack_count (== STACK_DEPTH / == 0).
REQ-016 SHALL have port boundary  output  1  registered one-cycle pulse: an inc/dec hit the page limit.
REQ-017 SHALL have port err  output  1  registered one-cycle pulse: illegal request dropped.

Function
REQ-018 SHALL evaluate requests once per rising edge; all outputs except stack_full/stack_empty change only on the edge (latency 1 cycle).
REQ-019 SHALL apply page-update priority: pop (stack non-empty) > load > inc/dec.
REQ-020 SHALL treat increment && decrement both high, or both low, as no inc/dec request.
REQ-021 SHALL, on increment at NUM_PAGES-1: wrap to 0 if SATURATE=0, hold if SATURATE=1; pulse boundary in either case.
REQ-022 SHALL, on decrement at 0: wrap to NUM_PAGES-1 if SATURATE=0, hold if SATURATE=1; pulse boundary in either case.
REQ-023 SHALL otherwise step mem_page by exactly +/-1 with no boundary pulse.
REQ-024 SHALL ignore load when load_val >= NUM_PAGES (mem_page unchanged by load, inc/dec also suppressed that cycle) and pulse err.
REQ-025 SHALL, on push when not full, write the pre-edge mem_page to stack[stack_count] and increment stack_count; push combines with load or inc/dec in the same cycle (old page saved, new page applied).
REQ-026 SHALL, on push when full, leave stack unchanged, pulse err, still apply load/inc/dec.
REQ-027 SHALL, on pop when non-empty, set mem_page to stack[stack_count-1], decrement stack_count, and ignore load/inc/dec that cycle.
REQ-028 SHALL, on pop when empty, leave stack and page-from-pop unchanged, pulse err, and apply load/inc/dec normally.
REQ-029 SHALL, on push && pop in the same cycle, change neither stack nor mem_page, ignore load/inc/dec, and pulse err.
REQ-030 SHALL pulse err at most once per cycle even if multiple error conditions coincide; boundary and err may pulse together.
REQ-031 SHALL never let stack_count exceed STACK_DEPTH or underflow below 0.

Reset
REQ-032 SHALL, while reset_n is low at a rising edge, set mem_page=0, stack_count=0, boundary=0, err=0, ignoring all other inputs.
REQ-033 SHALL discard stack contents on reset; entries are not readable until re-pushed, contents need not be cleared.
REQ-034 SHALL resume normal operation on the first rising edge with reset_n high; reset asserted mid-sequence aborts any pending request.

Verification
REQ-035 SHALL cover wrap: default params, reset, 8x increment -> mem_page 1..7 then 0, boundary pulse only on 8th edge; then 1x decrement -> 7 with boundary.
REQ-036 SHALL cover clamp: SATURATE=1, NUM_PAGES=6, PAGE_W=3, load 5 then increment -> mem_page stays 5, boundary=1, err=0; load_val=6 -> mem_page stays 5, err=1.
REQ-037 SHALL cover stack: load 3; push+load 6; push+increment; pop; pop -> mem_page 3,6,7,6,3; stack_count 0,1,2,1,0.
REQ-038 SHALL cover limits: STACK_DEPTH=4, 5x push -> stack_count 4, stack_full=1, err pulse on 5th only; 5x pop -> restores in LIFO order, err on 5th, stack_empty=1.
REQ-039 SHALL cover collisions: push && pop with stack_count=2, mem_page=4 -> both unchanged, err=1; increment && decrement -> mem_page unchanged, no pulses.
REQ-040 SHALL cover reset mid-operation: stack_count=3, mem_page=5, reset_n low one edge with increment high -> mem_page 0, stack_count 0, err 0, boundary 0; next pop -> err=1.
